// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the unified-memory access controller: FSM states,
// grant identifiers, funct3 size codes and the misalignment check.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_I,
    S_ISSUE_D,
    S_RESP_I,
    S_RESP_D
  } state_e;

  typedef enum logic {
    GRANT_INST,
    GRANT_DATA
  } grant_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    return ((f3[1:0] == 2'b10) && (lsb != 2'b00)) ||
           ((f3[1:0] == 2'b01) && lsb[0]);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_rsp_capture.sv
// Response registers: holds the last fetched instruction and the last load
// result, each with its own load enable and a shared synchronous clear.
module mem_rsp_capture #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              if_ld_i,
  input  logic              dm_ld_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic [DATA_W-1:0] dm_rdata_o
);

  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] dm_rdata_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      if_inst_q  <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_ld_i) if_inst_q  <= rdata_i;
      if (dm_ld_i) dm_rdata_q <= rdata_i;
    end
  end

  assign if_inst_o  = if_inst_q;
  assign dm_rdata_o = dm_rdata_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Serializes IF fetches and MEM loads/stores onto the single memory port.
// Optional MISALIGN_TRAP_EN: misaligned data accesses are trapped via dm_err.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_inst,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_f3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_ifetch,
  output logic [2:0]        mem_f3,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  grant_e            last_q;
  logic              if_ready_q, dm_ready_q, dm_err_q;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_read_q, mem_write_q, mem_ifetch_q;
  logic [2:0]        mem_f3_q;
  logic              if_pend, dm_pend, dm_mis;
  logic              pick_i, pick_d;

  // A request whose ready is showing this cycle has been served, not re-raised.
  assign if_pend = if_req & ~if_ready_q;
  assign dm_pend = dm_req & ~dm_ready_q;

`ifdef MISALIGN_TRAP_EN
  assign dm_mis = misaligned(dm_f3, dm_addr[1:0]);
`else
  assign dm_mis = 1'b0;
`endif

  always_comb begin
    pick_i  = 1'b0;
    pick_d  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (if_pend && dm_pend) begin
          pick_i = (last_q == GRANT_DATA);
          pick_d = (last_q == GRANT_INST);
        end else begin
          pick_i = if_pend;
          pick_d = dm_pend;
        end
      end
      S_RESP_I: pick_d = dm_pend;
      S_RESP_D: pick_i = if_pend;
      default: ;
    endcase
    unique case (state_q)
      S_ISSUE_I: state_d = S_RESP_I;
      S_ISSUE_D: state_d = S_RESP_D;
      default: begin
        if (pick_i)      state_d = S_ISSUE_I;
        else if (pick_d) state_d = dm_mis ? S_RESP_D : S_ISSUE_D;
        else             state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_q       <= GRANT_DATA;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      dm_err_q     <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_ifetch_q <= 1'b0;
      mem_f3_q     <= '0;
    end else begin
      state_q      <= state_d;
      if_ready_q   <= (state_q == S_RESP_I);
      dm_ready_q   <= (state_q == S_RESP_D);
      dm_err_q     <= (state_q == S_RESP_D) & err_q;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_ifetch_q <= 1'b0;
      mem_f3_q     <= '0;
      if (pick_i) begin
        last_q       <= GRANT_INST;
        mem_addr_q   <= if_addr;
        mem_ifetch_q <= 1'b1;
        mem_f3_q     <= F3_LW;
      end
      if (pick_d) begin
        last_q <= GRANT_DATA;
        we_q   <= dm_we;
        err_q  <= dm_mis;
        if (!dm_mis) begin
          mem_addr_q  <= dm_addr;
          mem_f3_q    <= dm_f3;
          mem_read_q  <= ~dm_we;
          mem_write_q <= dm_we;
          mem_wdata_q <= dm_we ? dm_wdata : '0;
        end
      end
    end
  end

  mem_rsp_capture #(.DATA_W(DATA_W)) u_rsp_capture (
    .clk        (clk),
    .clr_i      (~rst),
    .if_ld_i    (state_q == S_RESP_I),
    .dm_ld_i    ((state_q == S_RESP_D) & ~we_q & ~err_q),
    .rdata_i    (mem_rdata),
    .if_inst_o  (if_inst),
    .dm_rdata_o (dm_rdata)
  );

  // Enables are gated by rst so a reset landing on an issue cycle reaches the
  // memory's sampling edge with no access asserted.
  assign mem_read   = mem_read_q   & rst;
  assign mem_write  = mem_write_q  & rst;
  assign mem_ifetch = mem_ifetch_q & rst;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_f3     = mem_f3_q;

  assign if_ready = if_ready_q;
  assign dm_ready = dm_ready_q;
  assign dm_err   = dm_err_q;
  assign stall    = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a one-cycle-latency memory model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_inst;
  logic          dm_req;
  logic          dm_we;
  logic [2:0]    dm_f3;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;
  logic          dm_err;
  logic          stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic          mem_ifetch;
  logic [2:0]    mem_f3;
  logic [DW-1:0] mem_rdata;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
    .dm_req(dm_req), .dm_we(dm_we), .dm_f3(dm_f3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ifetch(mem_ifetch), .mem_f3(mem_f3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_read || mem_ifetch) mem_rdata <= mem[mem_addr[11:2]];
    if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {if_ready, if_inst, dm_ready, dm_rdata, dm_err, mem_addr, mem_wdata,
            mem_read, mem_write, mem_ifetch, mem_f3};
  endfunction

  typedef struct {
    logic          is_data;
    logic          we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    bit got = 0;
    int wr_cnt = 0;
    logic rdy;
    if (v.is_data) begin
      dm_req = 1'b1; dm_we = v.we; dm_f3 = v.f3; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (mem_write) wr_cnt++;
      rdy = v.is_data ? dm_ready : if_ready;
      if (k == 1) begin
        check($sformatf("v%0d_stall_busy", idx), stall, 1'b1);
        if (v.exp_err)
          check($sformatf("v%0d_trap_no_issue", idx), {mem_ifetch, mem_read, mem_write}, 3'b000);
        else if (!v.is_data)
          check($sformatf("v%0d_fetch_issue", idx), {mem_ifetch, mem_read, mem_write, mem_addr}, {3'b100, v.addr});
        else begin
          check($sformatf("v%0d_data_issue", idx), {mem_ifetch, mem_read, mem_write, mem_addr, mem_f3},
                {1'b0, ~v.we, v.we, v.addr, v.f3});
          if (v.we) check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
        end
      end
      if (rdy) begin
        got = 1;
        check($sformatf("v%0d_latency", idx), k, v.exp_err ? 2 : 3);
        check($sformatf("v%0d_stall_drop", idx), stall, 1'b0);
        if (!v.is_data)
          check($sformatf("v%0d_if_inst", idx), if_inst, v.exp_data);
        else begin
          check($sformatf("v%0d_dm_err", idx), dm_err, v.exp_err);
          if (!v.we) check($sformatf("v%0d_dm_rdata", idx), dm_rdata, v.exp_data);
        end
      end
    end
    if (!got) check($sformatf("v%0d_ready_timeout", idx), 1'b0, 1'b1);
    check($sformatf("v%0d_write_count", idx), wr_cnt, (v.we && !v.exp_err) ? 1 : 0);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_ready_pulse", idx), {if_ready, dm_ready, dm_err}, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[1] = 32'h0000_2083;

    vecs[0] = '{1'b1, 1'b1, F3_LW,  12'h00C, 32'h0000_0022, 32'h0,          1'b0};
    vecs[1] = '{1'b1, 1'b0, F3_LW,  12'h00C, 32'h0,          32'h0000_0022, 1'b0};
    vecs[2] = '{1'b0, 1'b0, F3_LW,  12'h010, 32'h0,          32'hA000_0004, 1'b0};
    vecs[3] = '{1'b1, 1'b1, F3_LW,  12'h020, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[4] = '{1'b1, 1'b0, F3_LW,  12'h020, 32'h0,          32'hDEAD_BEEF, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vecs[5] = '{1'b1, 1'b0, F3_LW,  12'h002, 32'h0,          32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, F3_LH,  12'h005, 32'h0,          32'hDEAD_BEEF, 1'b1};
`else
    vecs[5] = '{1'b1, 1'b0, F3_LW,  12'h002, 32'h0,          32'hA000_0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, F3_LH,  12'h005, 32'h0,          32'h0000_2083, 1'b0};
`endif
    vecs[7] = '{1'b1, 1'b0, F3_LHU, 12'h006, 32'h0,          32'h0000_2083, 1'b0};
    vecs[8] = '{1'b0, 1'b0, F3_LW,  12'h004, 32'h0,          32'h0000_2083, 1'b0};

    rst = 1'b0; if_req = 1'b1; if_addr = 12'h004;
    dm_req = 1'b0; dm_we = 1'b0; dm_f3 = F3_LW; dm_addr = '0; dm_wdata = '0;

    // Reset held with a fetch pending, then released.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_outputs_zero", all_outs(), '0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_issue_i", {mem_ifetch, mem_read, mem_write, mem_addr}, {3'b100, 12'h004});
    @(negedge clk);
    check("fetch_resp_stall", {if_ready, stall}, 2'b01);
    @(negedge clk);
    check("fetch_ready", {if_ready, stall, if_inst}, {2'b10, 32'h0000_2083});
    if_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Contention after a fetch: data wins first, then strict alternation.
    dm_we = 1'b0; dm_f3 = F3_LW; dm_addr = 12'h00C; if_addr = 12'h010;
    dm_req = 1'b1; if_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("cont_k%0d", k), {mem_read, mem_ifetch, dm_ready, if_ready},
            {(k == 1 || k == 5 || k == 9), (k == 3 || k == 7),
             (k == 3 || k == 7 || k == 11), (k == 5 || k == 9)});
      if (k == 9) begin
        check("cont_if_inst", if_inst, 32'hA000_0004);
        dm_req = 1'b0; if_req = 1'b0;
      end
      if (k == 11) check("cont_dropped_completes", dm_rdata, 32'h0000_0022);
    end
    @(negedge clk);
    check("cont_idle", {mem_read, mem_ifetch, dm_ready, if_ready}, 4'b0000);

    // Reset landing on the issue cycle of a store.
    dm_we = 1'b1; dm_f3 = F3_LW; dm_addr = 12'h030; dm_wdata = 32'h55; dm_req = 1'b1;
    @(negedge clk);
    check("abort_issue_d", mem_write, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_write_gated", mem_write, 1'b0);
    @(negedge clk);
    check("abort_outputs_zero", all_outs(), '0);
    dm_req = 1'b0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_ready", {dm_ready, mem_write}, 2'b00);
    end
    check("abort_mem_untouched", mem[12], 32'hA000_000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
